mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter RET_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 Op  input  6  instruction opcode field from the instruction register.
REQ-005 mem_ready  input  1  memory handshake; access completes in any cycle where it is 1.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-007 PCSource  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-008 ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left by 2.
REQ-009 ALUOp  output  2  fed to alu_ctrl; values are the `lwOP/`swOP, `beqOP and `RtypeOP macros from define/ctrl_encode_def.v.
REQ-010 state  output  4  current FSM state, for debug.
REQ-011 illegal  output  1  unsupported-opcode flag.
REQ-012 retired  output  RET_W  count of completed instructions.

Function
REQ-013 Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9; codes 10-15 unreachable and return to FETCH next cycle.
REQ-014 Supported opcodes: lw 0x23, sw 0x2B, R-type 0x00, beq 0x04, j 0x02.
REQ-015 Any output not listed for a state is 0 in that state.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=`lwOP, PCSource=00.
REQ-016a FETCH: IRWrite=PCWrite=mem_ready; this is the only Mealy term.
REQ-016b FETCH holds while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=`lwOP.
REQ-017a DECODE next state: lw/sw -> MEMADR, R-type -> EXEC, beq -> BRANCH, j -> JUMP, other -> FETCH.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=`lwOP; next is MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: MemRead=1, IorD=1; holds until mem_ready=1, then MEMWB.
REQ-020 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; holds until mem_ready=1, then FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=`RtypeOP; next ALUWB. Funct is not examined here.
REQ-023 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=`beqOP, PCWriteCond=1, PCSource=01; next FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-026 Op is sampled only in DECODE and MEMADR; changes on Op in other states have no effect.
REQ-027 illegal is 1 combinationally during a DECODE cycle with an unsupported Op, else 0; retired does not increment for it.
REQ-028 retired increments by 1 on the clock edge leaving each of: MEMWB, ALUWB, BRANCH, JUMP, and MEMWR with mem_ready=1. It wraps from 2^RET_W-1 to 0.
REQ-029 Latency from FETCH entry to next FETCH entry with mem_ready constantly 1:
- lw: 5 cycles
- sw, R-type: 4 cycles
- beq, j: 3 cycles

Reset
REQ-030 While rst=1: state=FETCH, retired=0, illegal=0.
REQ-030a While rst=1: PCWrite, PCWriteCond, IRWrite, MemWrite and RegWrite are forced to 0 regardless of mem_ready.
REQ-031 Assertion of rst at any point, including while stalled in MEMRD/MEMWR, aborts the instruction immediately without incrementing retired. The first FETCH cycle occurs on the first rising edge after deassertion.

Verification
REQ-032 Reset then mem_ready=1, Op=0x23 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; retired=1.
REQ-033 Op=0x2B with mem_ready low for 3 cycles in MEMWR -> state stays 5 with MemWrite=1 for 4 cycles, then 0; retired +1 only after mem_ready=1.
REQ-034 Op=0x00 then 0x04 then 0x02 back-to-back -> ALUOp=`RtypeOP in EXEC; PCWriteCond=1, PCSource=01 in BRANCH; PCWrite=1, PCSource=10 in JUMP; retired=3 after 10 cycles.
REQ-035 Op=0x3F -> illegal=1 for exactly the DECODE cycle, next state 0, retired unchanged.
REQ-036 rst pulsed while in MEMRD with mem_ready=0 -> state=0 and retired=0 asynchronously, all write enables 0 during reset.
REQ-037 With RET_W=4, run 16 R-type instructions -> retired wraps 15 -> 0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// ============================================================================
// Module   : mc_ctrl_if
// Purpose  : Opcode/memory-handshake inputs and datapath control outputs
//            of the multicycle controller, bundled with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_ctrl_if #(
    parameter int RET_W = 32
);
    logic [5:0]       Op;
    logic             mem_ready;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             ALUSrcA;
    logic             RegWrite;
    logic             RegDst;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [3:0]       state;
    logic             illegal;
    logic [RET_W-1:0] retired;

    // Controller side
    modport master (
        input  Op, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, state, illegal, retired
    );

    // Datapath side
    modport slave (
        output Op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, state, illegal, retired
    );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multicycle MIPS-subset control FSM (lw/sw/R-type/beq/j) with
//            illegal-opcode flag and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef lwOP
`define lwOP    2'b00
`endif
`ifndef swOP
`define swOP    2'b00
`endif
`ifndef beqOP
`define beqOP   2'b01
`endif
`ifndef RtypeOP
`define RtypeOP 2'b10
`endif

module mc_ctrl #(
    parameter int RET_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master mc
);

    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [RET_W-1:0] r_retired;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_mem_to_reg;
    logic       w_ir_write;
    logic       w_alu_src_a;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic [1:0] w_pc_source;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_illegal;
    logic       w_retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt           = ST_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_ir_write      = 1'b0;
        w_alu_src_a     = 1'b0;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_pc_source     = 2'b00;
        w_alu_src_b     = 2'b00;
        w_alu_op        = `lwOP;
        w_illegal       = 1'b0;
        w_retire        = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_op    = `lwOP;
                // IR load and PC+4 commit only once the fetch returns
                w_ir_write  = mc.mem_ready;
                w_pc_write  = mc.mem_ready;
                w_nxt       = mc.mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                w_alu_src_b = 2'b11;
                w_alu_op    = `lwOP;
                case (mc.Op)
                    c_OP_LW,
                    c_OP_SW:    w_nxt = ST_MEMADR;
                    c_OP_RTYPE: w_nxt = ST_EXEC;
                    c_OP_BEQ:   w_nxt = ST_BRANCH;
                    c_OP_J:     w_nxt = ST_JUMP;
                    default: begin
                        w_nxt     = ST_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = `lwOP;
                w_nxt       = (mc.Op == c_OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                w_nxt      = mc.mem_ready ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_nxt        = ST_FETCH;
            end
            ST_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_retire    = mc.mem_ready;
                w_nxt       = mc.mem_ready ? ST_FETCH : ST_MEMWR;
            end
            ST_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b00;
                w_alu_op    = `RtypeOP;
                w_nxt       = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
                w_nxt       = ST_FETCH;
            end
            ST_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = 2'b00;
                w_alu_op        = `beqOP;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_retire        = 1'b1;
                w_nxt           = ST_FETCH;
            end
            ST_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_retire    = 1'b1;
                w_nxt       = ST_FETCH;
            end
            default: begin
                w_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + RET_W'(1);
        end
    end

    // Architectural write enables are held off for the whole reset window,
    // including the mem_ready-driven FETCH terms.
    assign mc.PCWrite     = w_pc_write      & ~rst;
    assign mc.PCWriteCond = w_pc_write_cond & ~rst;
    assign mc.IRWrite     = w_ir_write      & ~rst;
    assign mc.MemWrite    = w_mem_write     & ~rst;
    assign mc.RegWrite    = w_reg_write     & ~rst;

    assign mc.IorD     = w_iord;
    assign mc.MemRead  = w_mem_read;
    assign mc.MemtoReg = w_mem_to_reg;
    assign mc.ALUSrcA  = w_alu_src_a;
    assign mc.RegDst   = w_reg_dst;
    assign mc.PCSource = w_pc_source;
    assign mc.ALUSrcB  = w_alu_src_b;
    assign mc.ALUOp    = w_alu_op;
    assign mc.state    = r_state;
    assign mc.illegal  = w_illegal;
    assign mc.retired  = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed self-checking bench for mc_ctrl (RET_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    localparam int c_RET_W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mc_ctrl_if #(.RET_W(c_RET_W)) bus ();

    mc_ctrl #(.RET_W(c_RET_W)) dut (
        .clk (clk),
        .rst (rst),
        .mc  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.Op        = 6'h00;
        bus.mem_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_state",   32'(bus.state),   32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_irwrite", 32'(bus.IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(bus.PCWrite), 32'd0);

        // lw: 0,1,2,3,4,0
        @(negedge clk);
        rst    = 1'b0;
        bus.Op = 6'h23;
        #1;
        chk("lw_f_state",   32'(bus.state),   32'd0);
        chk("lw_f_memread", 32'(bus.MemRead), 32'd1);
        chk("lw_f_irwrite", 32'(bus.IRWrite), 32'd1);
        chk("lw_f_pcwrite", 32'(bus.PCWrite), 32'd1);
        chk("lw_f_srcb",    32'(bus.ALUSrcB), 32'd1);
        tick();
        chk("lw_d_state",   32'(bus.state),   32'd1);
        chk("lw_d_srcb",    32'(bus.ALUSrcB), 32'd3);
        chk("lw_d_irwrite", 32'(bus.IRWrite), 32'd0);
        tick();
        chk("lw_ma_state",  32'(bus.state),   32'd2);
        chk("lw_ma_srca",   32'(bus.ALUSrcA), 32'd1);
        chk("lw_ma_srcb",   32'(bus.ALUSrcB), 32'd2);
        tick();
        chk("lw_mr_state",  32'(bus.state),   32'd3);
        chk("lw_mr_iord",   32'(bus.IorD),    32'd1);
        chk("lw_mr_regwr",  32'(bus.RegWrite), 32'd0);
        tick();
        chk("lw_wb_state",  32'(bus.state),    32'd4);
        chk("lw_wb_regwr",  32'(bus.RegWrite), 32'd1);
        chk("lw_wb_m2r",    32'(bus.MemtoReg), 32'd1);
        chk("lw_wb_regdst", 32'(bus.RegDst),   32'd0);
        tick();
        chk("lw_end_state", 32'(bus.state),   32'd0);
        chk("lw_retired",   32'(bus.retired), 32'd1);

        // sw with mem_ready low for three MEMWR cycles
        bus.Op = 6'h2B;
        tick();
        chk("sw_d_state", 32'(bus.state), 32'd1);
        tick();
        chk("sw_ma_state", 32'(bus.state), 32'd2);
        bus.mem_ready = 1'b0;
        tick();
        chk("sw_w1_state", 32'(bus.state),    32'd5);
        chk("sw_w1_memwr", 32'(bus.MemWrite), 32'd1);
        tick();
        chk("sw_w2_state", 32'(bus.state),   32'd5);
        chk("sw_w2_ret",   32'(bus.retired), 32'd1);
        tick();
        chk("sw_w3_state", 32'(bus.state), 32'd5);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        chk("sw_w4_state", 32'(bus.state),    32'd5);
        chk("sw_w4_memwr", 32'(bus.MemWrite), 32'd1);
        chk("sw_w4_ret",   32'(bus.retired),  32'd1);
        tick();
        chk("sw_end_state", 32'(bus.state),   32'd0);
        chk("sw_retired",   32'(bus.retired), 32'd2);

        // R-type, beq, j back-to-back (10 cycles, +3 retired)
        bus.Op = 6'h00;
        tick();
        tick();
        chk("r_ex_state", 32'(bus.state),   32'd6);
        chk("r_ex_aluop", 32'(bus.ALUOp),   32'd2);
        chk("r_ex_srca",  32'(bus.ALUSrcA), 32'd1);
        chk("r_ex_srcb",  32'(bus.ALUSrcB), 32'd0);
        bus.Op = 6'h04;  // ignored outside DECODE/MEMADR
        tick();
        chk("r_wb_state",  32'(bus.state),    32'd7);
        chk("r_wb_regdst", 32'(bus.RegDst),   32'd1);
        chk("r_wb_regwr",  32'(bus.RegWrite), 32'd1);
        tick();
        chk("r_end_state", 32'(bus.state), 32'd0);
        tick();
        tick();
        chk("beq_state", 32'(bus.state),       32'd8);
        chk("beq_pwc",   32'(bus.PCWriteCond), 32'd1);
        chk("beq_psrc",  32'(bus.PCSource),    32'd1);
        chk("beq_aluop", 32'(bus.ALUOp),       32'd1);
        chk("beq_pcw",   32'(bus.PCWrite),     32'd0);
        bus.Op = 6'h02;
        tick();
        tick();
        tick();
        chk("j_state", 32'(bus.state),    32'd9);
        chk("j_pcw",   32'(bus.PCWrite),  32'd1);
        chk("j_psrc",  32'(bus.PCSource), 32'd2);
        tick();
        chk("j_end_state", 32'(bus.state),   32'd0);
        chk("rbj_retired", 32'(bus.retired), 32'd5);

        // Illegal opcode
        bus.Op = 6'h3F;
        #1;
        chk("ill_f_flag", 32'(bus.illegal), 32'd0);
        tick();
        chk("ill_d_state", 32'(bus.state),   32'd1);
        chk("ill_d_flag",  32'(bus.illegal), 32'd1);
        tick();
        chk("ill_end_state", 32'(bus.state),   32'd0);
        chk("ill_end_flag",  32'(bus.illegal), 32'd0);
        chk("ill_retired",   32'(bus.retired), 32'd5);

        // Asynchronous reset while stalled in MEMRD
        bus.Op = 6'h23;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        chk("ar_pre_state", 32'(bus.state), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_state",   32'(bus.state),   32'd0);
        chk("ar_retired", 32'(bus.retired), 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        chk("ar_irwrite", 32'(bus.IRWrite),     32'd0);
        chk("ar_pcwrite", 32'(bus.PCWrite),     32'd0);
        chk("ar_pwc",     32'(bus.PCWriteCond), 32'd0);
        chk("ar_memwr",   32'(bus.MemWrite),    32'd0);
        chk("ar_regwr",   32'(bus.RegWrite),    32'd0);
        tick();
        chk("ar_hold_state", 32'(bus.state), 32'd0);

        // 16 R-type instructions: retired wraps 15 -> 0
        @(negedge clk);
        rst    = 1'b0;
        bus.Op = 6'h00;
        for (int i = 0; i < 16; i++) begin
            repeat (4) tick();
            if (i == 14) begin
                chk("wrap_pre", 32'(bus.retired), 32'd15);
            end
        end
        chk("wrap_post",  32'(bus.retired), 32'd0);
        chk("wrap_state", 32'(bus.state),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
